// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command parser: FSM states,
// command/response byte codes and the default argument timeout.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_ARG  = 3'd1,
    RESP_WAIT = 3'd2,
    RESP_SEND = 3'd3,
    RESP_DONE = 3'd4
  } state_e;

  localparam logic [7:0] CHAR_M = 8'h4D;
  localparam logic [7:0] CHAR_R = 8'h52;
  localparam logic [7:0] CHAR_1 = 8'h31;
  localparam logic [7:0] CHAR_K = 8'h4B;
  localparam logic [7:0] CHAR_E = 8'h45;

  localparam int unsigned CMD_TIMEOUT_CLKS_DEF = 17360;

  // Move arguments are the ASCII digits '1'..'9'
  function automatic logic is_cell_digit(input logic [7:0] b);
    return (b >= CHAR_1) && (b <= (CHAR_1 + 8'd8));
  endfunction

endpackage

// File: rtl/cmd_timer.sv
// Argument timeout: a down-counter loaded by clear and decremented while
// enabled; expired flags the terminal count on an enabled cycle.
module cmd_timer #(
  parameter int unsigned LOAD = 17360
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned W = (LOAD > 1) ? $clog2(LOAD) : 1;
  localparam logic [W-1:0] LOAD_M1 = W'(LOAD - 1);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = LOAD_M1;
    end else if (enable && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Loaded with LOAD-1, so zero is reached on the LOAD-th enabled cycle
  assign expired = enable && !clear && (count_q == '0);

endmodule

// File: rtl/uart_cmd_parser.sv
// Byte-level command parser between uart_rx and uart_tx for the game board.
// Define UART_CMD_TIMEOUT_EN to abort a pending 'M' after CMD_TIMEOUT_CLKS idle clocks.
//
//   state     | meaning
//   IDLE      | waiting for a command byte
//   WAIT_ARG  | 'M' received, waiting for the cell digit
//   RESP_WAIT | response latched, waiting for uart_tx to go idle
//   RESP_SEND | tx_data_valid pulse cycle
//   RESP_DONE | waiting for tx_done
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int unsigned CMD_TIMEOUT_CLKS = CMD_TIMEOUT_CLKS_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_data_valid,
  input  logic [7:0] rx_byte,
  input  logic       tx_active,
  input  logic       tx_done,
  output logic       tx_data_valid,
  output logic [7:0] tx_byte,
  output logic       move_valid,
  output logic [3:0] move_cell,
  output logic       game_reset,
  output logic       cmd_error,
  output logic       busy
);

  state_e     state_q, state_d;
  logic [7:0] tx_byte_q, tx_byte_d;
  logic [3:0] move_cell_q, move_cell_d;
  logic       tx_data_valid_q, tx_data_valid_d;
  logic       move_valid_q, move_valid_d;
  logic       game_reset_q, game_reset_d;
  logic       cmd_error_q, cmd_error_d;
  logic       timeout;

`ifdef UART_CMD_TIMEOUT_EN
  logic timer_clear, timer_en;

  assign timer_clear = (state_q == IDLE) && rx_data_valid && (rx_byte == CHAR_M);
  assign timer_en    = (state_q == WAIT_ARG);

  cmd_timer #(.LOAD(CMD_TIMEOUT_CLKS)) u_cmd_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (timer_clear),
    .enable  (timer_en),
    .expired (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d         = state_q;
    tx_byte_d       = tx_byte_q;
    move_cell_d     = move_cell_q;
    tx_data_valid_d = 1'b0;
    move_valid_d    = 1'b0;
    game_reset_d    = 1'b0;
    cmd_error_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_data_valid) begin
          if (rx_byte == CHAR_M) begin
            state_d = WAIT_ARG;
          end else if (rx_byte == CHAR_R) begin
            game_reset_d = 1'b1;
            tx_byte_d    = CHAR_K;
            state_d      = RESP_WAIT;
          end else begin
            cmd_error_d = 1'b1;
            tx_byte_d   = CHAR_E;
            state_d     = RESP_WAIT;
          end
        end
      end
      WAIT_ARG: begin
        // A byte landing on the timeout cycle wins over the timeout
        if (rx_data_valid) begin
          if (is_cell_digit(rx_byte)) begin
            move_valid_d = 1'b1;
            move_cell_d  = 4'(rx_byte - CHAR_1);
            tx_byte_d    = CHAR_K;
          end else begin
            cmd_error_d = 1'b1;
            tx_byte_d   = CHAR_E;
          end
          state_d = RESP_WAIT;
        end else if (timeout) begin
          cmd_error_d = 1'b1;
          tx_byte_d   = CHAR_E;
          state_d     = RESP_WAIT;
        end
      end
      RESP_WAIT: begin
        if (!tx_active) begin
          tx_data_valid_d = 1'b1;
          state_d         = RESP_SEND;
        end
      end
      RESP_SEND: state_d = RESP_DONE;
      RESP_DONE: begin
        if (tx_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      tx_byte_q       <= 8'h00;
      move_cell_q     <= 4'd0;
      tx_data_valid_q <= 1'b0;
      move_valid_q    <= 1'b0;
      game_reset_q    <= 1'b0;
      cmd_error_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      tx_byte_q       <= tx_byte_d;
      move_cell_q     <= move_cell_d;
      tx_data_valid_q <= tx_data_valid_d;
      move_valid_q    <= move_valid_d;
      game_reset_q    <= game_reset_d;
      cmd_error_q     <= cmd_error_d;
    end
  end

  assign tx_data_valid = tx_data_valid_q;
  assign tx_byte       = tx_byte_q;
  assign move_valid    = move_valid_q;
  assign move_cell     = move_cell_q;
  assign game_reset    = game_reset_q;
  assign cmd_error     = cmd_error_q;
  assign busy          = (state_q == RESP_WAIT) || (state_q == RESP_SEND) ||
                         (state_q == RESP_DONE);

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser: directed protocol cases plus
// randomized commands compared against a command-level reference model.
module tb_uart_cmd_parser;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_data_valid;
  logic [7:0] rx_byte;
  logic       tx_active;
  logic       tx_done;
  logic       tx_data_valid;
  logic [7:0] tx_byte;
  logic       move_valid;
  logic [3:0] move_cell;
  logic       game_reset;
  logic       cmd_error;
  logic       busy;

  uart_cmd_parser #(.CMD_TIMEOUT_CLKS(50)) dut (
    .clk           (clk),
    .reset         (reset),
    .rx_data_valid (rx_data_valid),
    .rx_byte       (rx_byte),
    .tx_active     (tx_active),
    .tx_done       (tx_done),
    .tx_data_valid (tx_data_valid),
    .tx_byte       (tx_byte),
    .move_valid    (move_valid),
    .move_cell     (move_cell),
    .game_reset    (game_reset),
    .cmd_error     (cmd_error),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output pulse monitor, sampled away from the active edge
  int cnt_move = 0, cnt_rst = 0, cnt_err = 0, cnt_txv = 0, cnt_multi = 0;
  always @(negedge clk) begin
    if (!reset) begin
      cnt_move += int'(move_valid);
      cnt_rst  += int'(game_reset);
      cnt_err  += int'(cmd_error);
      cnt_txv  += int'(tx_data_valid);
      if (int'(move_valid) + int'(game_reset) + int'(cmd_error) > 1) cnt_multi++;
    end
  end

  // Reference model: what a command (first byte, optional argument) must produce
  int mdl_cell = 0;
  localparam int KIND_MOVE = 0, KIND_RST = 1, KIND_ERR = 2;

  function automatic void model_cmd(input logic [7:0] b0, input logic [7:0] b1,
                                    output int kind, output logic [7:0] resp);
    if (b0 == 8'h4D) begin
      if (b1 >= 8'h31 && b1 <= 8'h39) begin
        kind = KIND_MOVE; resp = 8'h4B;
      end else begin
        kind = KIND_ERR; resp = 8'h45;
      end
    end else if (b0 == 8'h52) begin
      kind = KIND_RST; resp = 8'h4B;
    end else begin
      kind = KIND_ERR; resp = 8'h45;
    end
  endfunction

  task automatic send_byte(input logic [7:0] b);
    rx_byte       = b;
    rx_data_valid = 1'b1;
    @(negedge clk);
    rx_data_valid = 1'b0;
  endtask

  // Hold tx_active for 'pre' cycles, then play uart_tx for one response
  task automatic finish_resp(input logic [7:0] resp, input int pre, input bit inject);
    int s_txv;
    int waited;
    int hold;
    s_txv = cnt_txv;
    for (int i = 0; i < pre; i++) begin
      if (inject && i == pre / 2) send_byte(8'h52);
      else @(negedge clk);
    end
    if (pre > 0) check_eq("txv_while_tx_active", cnt_txv - s_txv, 0);
    tx_active = 1'b0;
    waited = 0;
    while (!tx_data_valid && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    check_eq("txv_seen", tx_data_valid, 1);
    check_eq("tx_byte_at_send", tx_byte, resp);
    tx_active = 1'b1;
    @(negedge clk);
    check_eq("txv_one_cycle", tx_data_valid, 0);
    hold = $urandom_range(2, 6);
    for (int i = 0; i < hold; i++) begin
      if (inject && i == 1) send_byte(8'h4D);
      else @(negedge clk);
    end
    tx_done = 1'b1;
    @(negedge clk);
    tx_done   = 1'b0;
    tx_active = 1'b0;
    check_eq("tx_byte_stable", tx_byte, resp);
    check_eq("busy_after_done", busy, 0);
    check_eq("txv_count", cnt_txv - s_txv, 1);
  endtask

  task automatic run_cmd(input logic [7:0] b0, input logic [7:0] b1, input int gap,
                         input int pre, input bit inject);
    int kind;
    logic [7:0] resp;
    int s_move, s_rst, s_err;
    s_move = cnt_move; s_rst = cnt_rst; s_err = cnt_err;
    model_cmd(b0, b1, kind, resp);
    if (kind == KIND_MOVE) mdl_cell = int'(b1) - 8'h31;
    tx_active = (pre > 0);
    send_byte(b0);
    if (b0 == 8'h4D) begin
      repeat (gap) @(negedge clk);
      send_byte(b1);
    end
    check_eq("busy_after_cmd", busy, 1);
    finish_resp(resp, pre, inject);
    check_eq("move_pulses", cnt_move - s_move, (kind == KIND_MOVE) ? 1 : 0);
    check_eq("reset_pulses", cnt_rst - s_rst, (kind == KIND_RST) ? 1 : 0);
    check_eq("error_pulses", cnt_err - s_err, (kind == KIND_ERR) ? 1 : 0);
    check_eq("move_cell", move_cell, mdl_cell);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int s_err;
    int s_txv;
    int k;
    logic [7:0] b0, b1;
    reset = 1'b1; rx_data_valid = 1'b0; rx_byte = 8'h00;
    tx_active = 1'b0; tx_done = 1'b0;
    #3;
    check_eq("rst_tx_data_valid", tx_data_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_tx_byte", tx_byte, 8'h00);
    check_eq("rst_move_cell", move_cell, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    run_cmd(8'h4D, 8'h35, 0, 0, 0);     // move cell 4
    run_cmd(8'h52, 8'h00, 0, 0, 0);     // game reset
    run_cmd(8'h58, 8'h00, 0, 0, 0);     // unknown command
    run_cmd(8'h4D, 8'h30, 3, 0, 0);     // '0' below range
    run_cmd(8'h4D, 8'h3A, 1, 0, 0);     // ':' above range
    run_cmd(8'h4D, 8'h31, 2, 0, 0);
    run_cmd(8'h4D, 8'h39, 0, 0, 0);
    run_cmd(8'h52, 8'h00, 0, 100, 1);   // tx busy 100 cycles, 'R' ignored
    run_cmd(8'h4D, 8'h37, 49, 0, 0);    // argument on the timeout cycle

    s_err = cnt_err;
`ifdef UART_CMD_TIMEOUT_EN
    send_byte(8'h4D);
    k = 0;
    while (!cmd_error && k < 60) begin
      @(negedge clk);
      k++;
    end
    check_eq("timeout_cycle", k, 50);
    check_eq("timeout_err_pulses", cnt_err - s_err, 1);
    finish_resp(8'h45, 0, 0);
`else
    send_byte(8'h4D);
    repeat (200) @(negedge clk);
    check_eq("no_timeout_err", cnt_err - s_err, 0);
    check_eq("still_wait_arg_busy", busy, 0);
    send_byte(8'h32);
    mdl_cell = 1;
    check_eq("late_arg_move", move_valid, 1);
    finish_resp(8'h4B, 0, 0);
    check_eq("late_arg_cell", move_cell, mdl_cell);
`endif

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 2))
        0: b0 = 8'h4D;
        1: b0 = 8'h52;
        default: b0 = 8'($urandom);
      endcase
      b1 = ($urandom_range(0, 1) == 1) ? 8'(8'h31 + $urandom_range(0, 8)) : 8'($urandom);
      run_cmd(b0, b1, $urandom_range(0, 10), $urandom_range(0, 5), 1'($urandom_range(0, 1)));
    end

    // Reset while waiting for tx_done
    run_cmd(8'h4D, 8'h36, 0, 0, 0);
    send_byte(8'h52);
    k = 0;
    while (!tx_data_valid && k < 10) begin
      @(negedge clk);
      k++;
    end
    check_eq("pre_reset_txv", tx_data_valid, 1);
    tx_active = 1'b1;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check_eq("async_rst_busy", busy, 0);
    check_eq("async_rst_tx_byte", tx_byte, 8'h00);
    check_eq("async_rst_move_cell", move_cell, 0);
    check_eq("async_rst_pulses", {tx_data_valid, move_valid, game_reset, cmd_error}, 0);
    mdl_cell = 0;
    @(negedge clk);
    reset = 1'b0;
    tx_active = 1'b0;
    s_txv = cnt_txv;
    repeat (10) @(negedge clk);
    check_eq("no_txv_after_reset", cnt_txv - s_txv, 0);
    run_cmd(8'h4D, 8'h31, 0, 0, 0);

    check_eq("pulse_exclusive", cnt_multi, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_cmd_parser.md
UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 SHALL have parameter CMD_TIMEOUT_CLKS, default 17360, meaning the maximum clocks allowed between a command byte and its argument byte.
REQ-002 SHALL have port clk, input, 1, system clock; all logic SHALL be clocked on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port rx_data_valid, input, 1, one-cycle pulse from uart_rx marking a new received byte.
REQ-005 SHALL have port rx_byte, input, 8, received byte, valid while rx_data_valid is high.
REQ-006 SHALL have port tx_active, input, 1, uart_tx busy flag.
REQ-007 SHALL have port tx_done, input, 1, uart_tx one-cycle completion pulse.
REQ-008 SHALL have port tx_data_valid, output, 1, one-cycle start pulse to uart_tx.
REQ-009 SHALL have port tx_byte, output, 8, response byte to uart_tx.
REQ-010 SHALL have port move_valid, output, 1, one-cycle pulse for an accepted move.
REQ-011 SHALL have port move_cell, output, 4, board cell index 0-8, valid with move_valid.
REQ-012 SHALL have port game_reset, output, 1, one-cycle pulse for an accepted reset command.
REQ-013 SHALL have port cmd_error, output, 1, one-cycle pulse for a rejected or timed-out command.
REQ-014 SHALL have port busy, output, 1, high while a response is pending or transmitting.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT_ARG, RESP_WAIT, RESP_SEND and RESP_DONE.
REQ-016 In IDLE, on rx_data_valid with rx_byte 0x4D ('M'), the FSM SHALL go to WAIT_ARG and clear the timeout counter.
REQ-017 In IDLE, on rx_data_valid with rx_byte 0x52 ('R'), the block SHALL pulse game_reset the next cycle and go to RESP_WAIT with response 0x4B ('K').
REQ-018 In IDLE, any other received byte SHALL pulse cmd_error the next cycle and go to RESP_WAIT with response 0x45 ('E').
REQ-019 In WAIT_ARG, on rx_data_valid with rx_byte 0x31-0x39 ('1'-'9'), the block SHALL pulse move_valid the next cycle with move_cell = rx_byte - 0x31, and go to RESP_WAIT with response 'K'.
REQ-020 In WAIT_ARG, any other received byte SHALL pulse cmd_error the next cycle and select response 'E'.
REQ-021 In RESP_WAIT, the FSM SHALL move to RESP_SEND on the first cycle tx_active is low.
REQ-022 In RESP_SEND, tx_data_valid SHALL be high for exactly one cycle, then the FSM SHALL enter RESP_DONE.
REQ-023 tx_byte SHALL be stable from RESP_WAIT entry until RESP_DONE exit.
REQ-024 In RESP_DONE, on tx_done the FSM SHALL return to IDLE.
REQ-025 rx_data_valid in RESP_WAIT, RESP_SEND or RESP_DONE SHALL be ignored, with no output pulse.
REQ-026 busy SHALL be high exactly in RESP_WAIT, RESP_SEND and RESP_DONE.
REQ-027 move_valid, game_reset and cmd_error SHALL be mutually exclusive, and at most one SHALL pulse per command.
REQ-028 move_cell SHALL hold its last value between pulses.

Reset
REQ-029 On reset assertion, regardless of clock, the state SHALL be IDLE and tx_data_valid, move_valid, game_reset, cmd_error and busy SHALL be 0.
REQ-030 On reset assertion, tx_byte SHALL be 0x00, move_cell SHALL be 0 and the timeout counter SHALL be 0.
REQ-031 Reset mid-response SHALL abandon the response with no tx_data_valid pulse afterwards.

Configuration
REQ-032 With UART_CMD_TIMEOUT_EN defined, in WAIT_ARG, after CMD_TIMEOUT_CLKS cycles without rx_data_valid, the block SHALL pulse cmd_error and go to RESP_WAIT with response 'E'.
REQ-033 If rx_data_valid arrives on the timeout cycle, the byte SHALL take priority over the timeout.
REQ-034 Without UART_CMD_TIMEOUT_EN defined, WAIT_ARG SHALL wait indefinitely and the counter logic SHALL be absent.

Structure
REQ-035 Package uart_cmd_pkg SHALL hold the state enum, the byte constants 'M', 'R', '1', 'K' and 'E', and the default for CMD_TIMEOUT_CLKS.
REQ-036 The timeout counter SHALL be a sub-module, cmd_timer, with ports clk, reset, clear, enable and expired.

Verification
REQ-037 Bytes 0x4D then 0x35 -> one move_valid pulse with move_cell=4, then one tx_data_valid with tx_byte=0x4B.
REQ-038 Byte 0x52 -> one game_reset pulse, then response 0x4B; move_valid stays 0.
REQ-039 Byte 0x58, and separately 0x4D then 0x30 -> each gives one cmd_error pulse and response 0x45.
REQ-040 With tx_active held high for 100 cycles -> tx_data_valid is delayed until tx_active falls; byte 0x52 sent during the response is ignored.
REQ-041 With UART_CMD_TIMEOUT_EN, CMD_TIMEOUT_CLKS=50: 0x4D then silence -> cmd_error on cycle 50, response 0x45; without the macro -> no cmd_error.
REQ-042 Reset asserted in RESP_DONE -> all outputs 0 at once; a following 0x4D, 0x31 -> move_cell=0 and response 0x4B.
